nios2_fmeasure_multi: RTL and testbench

- Avalon-MM slave frequency meter, a successor to the single-word input PIO.
- Counts rising edges on NUM_CH slow input lines over a programmable gate window measured in clk cycles, then latches the per-channel counts into readable result registers.
- Sits on the Nios II data bus next to the other PIO peripherals and raises an optional IRQ at the end of each gate window.

---
 rtl/nios2_fmeasure_pkg.sv | 25 ++
 rtl/fmeasure_edge_cnt.sv | 68 ++++++
 rtl/nios2_fmeasure_multi.sv | 165 ++++++++++++++++
 tb/tb_nios2_fmeasure_multi.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_fmeasure_pkg.sv
// Shared register map, bit positions and FSM state type for the multi-channel
// Avalon-MM frequency meter.
package nios2_fmeasure_pkg;

  localparam logic [2:0] ADDR_CTRL        = 3'd0;
  localparam logic [2:0] ADDR_STATUS      = 3'd1;
  localparam logic [2:0] ADDR_GATE        = 3'd2;
  localparam logic [2:0] ADDR_RESULT_BASE = 3'd3;

  localparam int CTRL_CONT   = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ABORT  = 31;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/fmeasure_edge_cnt.sv
// One measured channel: optional 2-flop synchroniser (FMEASURE_SYNC_EN),
// rising-edge detect and a saturating edge counter.
module fmeasure_edge_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             in,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  import nios2_fmeasure_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  logic             rise;
  logic             s_d_q, s_d_d;
  logic [CNT_W-1:0] count_q, count_d;

`ifdef FMEASURE_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign s = sync_q[1];
`else
  assign s = in;
`endif

  always_comb begin
    // NOTE: every _d and output gets a default first, so no path can infer a latch.
    s_d_d   = s;
    count_d = count_q;
    sat     = 1'b0;
    rise    = s & ~s_d_q;
    if (clr) begin
      count_d = '0;
    end else if (en && rise) begin
      if (count_q == CNT_MAX) sat     = 1'b1;
      else                    count_d = count_q + CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_d_q   <= 1'b0;
      count_q <= '0;
    end else begin
      s_d_q   <= s_d_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/nios2_fmeasure_multi.sv
// Avalon-MM frequency meter: counts rising edges on NUM_CH inputs over a gate
// window of GATE clk cycles. Input synchroniser enabled by FMEASURE_SYNC_EN.
module nios2_fmeasure_multi #(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] GATE_RST = 32'd50000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] in_port,
  output logic              irq
);
  import nios2_fmeasure_pkg::*;

  state_e           state_q, state_d;
  logic             cont_q, cont_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      gate_q, gate_d;
  logic [31:0]      gate_cnt_q, gate_cnt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [CNT_W-1:0] result_q [NUM_CH];
  logic [CNT_W-1:0] result_d [NUM_CH];

  logic [CNT_W-1:0]  count [NUM_CH];
  logic [NUM_CH-1:0] sat;
  logic              cnt_clr, cnt_en, done_set;
  logic              wr, wr_ctrl, wr_status, wr_gate;
  logic              start_req, abort_req, cont_eff, busy;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    fmeasure_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .in      (in_port[ch]),
      .count   (count[ch]),
      .sat     (sat[ch])
    );
  end

  always_comb begin
    wr        = chipselect & ~write_n;
    wr_ctrl   = wr & (address == ADDR_CTRL);
    wr_status = wr & (address == ADDR_STATUS);
    wr_gate   = wr & (address == ADDR_GATE);
    start_req = wr_ctrl & writedata[CTRL_START];
    abort_req = wr_ctrl & writedata[CTRL_ABORT] & ~writedata[CTRL_CONT] & ~writedata[CTRL_START];
    // A cont write landing in the same cycle as the decision takes effect at once.
    cont_eff  = wr_ctrl ? writedata[CTRL_CONT] : cont_q;
    busy      = (state_q != ST_IDLE);

    state_d    = state_q;
    cont_d     = cont_q;
    irq_en_d   = irq_en_q;
    gate_d     = gate_q;
    gate_cnt_d = gate_cnt_q;
    result_d   = result_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    done_set   = 1'b0;

    if (wr_ctrl) begin
      cont_d   = writedata[CTRL_CONT];
      irq_en_d = writedata[CTRL_IRQ_EN];
    end
    if (wr_gate) gate_d = (writedata == 32'd0) ? 32'd1 : writedata;

    if (abort_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req || cont_eff) begin
            state_d    = ST_GATE;
            gate_cnt_d = gate_q - 32'd1;
            cnt_clr    = 1'b1;
          end
        end
        ST_GATE: begin
          cnt_en     = 1'b1;
          gate_cnt_d = gate_cnt_q - 32'd1;
          if (gate_cnt_q == 32'd0) state_d = ST_LATCH;
        end
        ST_LATCH: begin
          result_d = count;
          done_set = 1'b1;
          if (cont_eff) begin
            state_d    = ST_GATE;
            gate_cnt_d = gate_q - 32'd1;
            cnt_clr    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Sticky flags: a set in the same cycle as a W1C wins.
    done_d = done_q;
    if (wr_status && writedata[STAT_DONE]) done_d = 1'b0;
    if (done_set)                          done_d = 1'b1;
    ovf_d = ovf_q;
    if (wr_status && writedata[STAT_OVF]) ovf_d = 1'b0;
    if (|sat)                             ovf_d = 1'b1;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_CTRL: begin
        readdata_d[CTRL_CONT]   = cont_q;
        readdata_d[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_STATUS: begin
        readdata_d[STAT_BUSY] = busy;
        readdata_d[STAT_DONE] = done_q;
        readdata_d[STAT_OVF]  = ovf_q;
      end
      ADDR_GATE: readdata_d = gate_q;
      default: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (address == ADDR_RESULT_BASE + 3'(ch)) readdata_d = 32'(result_q[ch]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      gate_q     <= GATE_RST;
      gate_cnt_q <= '0;
      readdata_q <= '0;
      // NOTE: the result bank is a few flops rather than a RAM, so it is reset like any register.
      for (int ch = 0; ch < NUM_CH; ch++) result_q[ch] <= '0;
    end else begin
      state_q    <= state_d;
      cont_q     <= cont_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      gate_q     <= gate_d;
      gate_cnt_q <= gate_cnt_d;
      readdata_q <= readdata_d;
      result_q   <= result_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_nios2_fmeasure_multi.sv
// Directed bench for nios2_fmeasure_multi: a 32-bit and a 4-bit counter
// instance share one bus and input stimulus.
module tb_nios2_fmeasure_multi;
  import nios2_fmeasure_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata, readdata4;
  logic        irq, irq4;
  logic [3:0]  gen_bits = 4'd0;
  logic [3:0]  man_bits = 4'd0;
  wire  [3:0]  in_port = gen_bits | man_bits;
  int          period [4] = '{0, 0, 0, 0};
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rst_tbl [8];

  always #5 clk = ~clk;

  nios2_fmeasure_multi dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  nios2_fmeasure_multi #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4),
    .in_port(in_port), .irq(irq4)
  );

  // Periodic square waves; any window that is a multiple of the period sees
  // exactly window/period rising edges regardless of phase.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      for (int ch = 0; ch < 4; ch++)
        gen_bits[ch] = (period[ch] != 0 && (cyc % period[ch]) < period[ch] / 2) ? 1'b1 : 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d4);
    address = a;
    tick();
    d  = readdata;
    d4 = readdata4;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d, d4;
    bus_read(a, d, d4);
    check(name, d, exp);
  endtask

  task automatic wait_irq(input string name, input int budget, output int n);
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, irq}, 32'd1);
  endtask

  task automatic apply_rst_tbl();
    for (int i = 0; i < 8; i++) read_check(rst_tbl[i].name, rst_tbl[i].addr, rst_tbl[i].exp);
    check("rst_irq", {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] d, d4;
    int n;

    rst_tbl[0] = '{"rst_ctrl",    3'd0, 32'd0};
    rst_tbl[1] = '{"rst_status",  3'd1, 32'd0};
    rst_tbl[2] = '{"rst_gate",    3'd2, 32'd50000000};
    rst_tbl[3] = '{"rst_result0", 3'd3, 32'd0};
    rst_tbl[4] = '{"rst_result1", 3'd4, 32'd0};
    rst_tbl[5] = '{"rst_result2", 3'd5, 32'd0};
    rst_tbl[6] = '{"rst_result3", 3'd6, 32'd0};
    rst_tbl[7] = '{"rst_unused7", 3'd7, 32'd0};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // 1: reset state, unused address ignores writes
    apply_rst_tbl();
    bus_write(3'd7, 32'hdead_beef);
    read_check("unused_rd", 3'd7, 32'd0);
    read_check("gate_after_unused", ADDR_GATE, 32'd50000000);

    // 2: single window, GATE=100, periods 10 and 4
    period = '{10, 4, 0, 0};
    bus_write(ADDR_GATE, 32'd100);
    repeat (3) tick();
    bus_write(ADDR_CTRL, 32'd6);
    wait_irq("single_irq", 200, n);
    check("single_latency", 32'(n), 32'd101);
    read_check("single_res0", 3'd3, 32'd10);
    read_check("single_res1", 3'd4, 32'd25);
    read_check("single_res2", 3'd5, 32'd0);
    read_check("single_status", ADDR_STATUS, 32'd2);
    read_check("ctrl_readback", ADDR_CTRL, 32'd4);
    bus_write(ADDR_STATUS, 32'd2);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);

    // 3: continuous mode, GATE=20, period 5
    period = '{0, 0, 5, 0};
    bus_write(ADDR_STATUS, 32'd6);
    bus_write(ADDR_GATE, 32'd20);
    bus_write(ADDR_CTRL, 32'd5);
    wait_irq("cont_first", 100, n);
    bus_write(ADDR_STATUS, 32'd2);
    wait_irq("cont_second", 100, n);
    check("cont_period", 32'(n + 1), 32'd21);
    read_check("cont_res2", 3'd5, 32'd4);
    read_check("cont_busy", ADDR_STATUS, 32'd3);
    bus_write(ADDR_STATUS, 32'd2);
    bus_write(ADDR_CTRL, 32'd4);
    wait_irq("cont_last", 100, n);
    read_check("cont_stop_status", ADDR_STATUS, 32'd2);
    read_check("cont_res2_last", 3'd5, 32'd4);
    repeat (40) tick();
    read_check("cont_stays_idle", ADDR_STATUS, 32'd2);

    // 4: saturation on the 4-bit instance, GATE=100, period 2
    period = '{2, 0, 0, 0};
    bus_write(ADDR_STATUS, 32'd6);
    bus_write(ADDR_GATE, 32'd100);
    bus_write(ADDR_CTRL, 32'd6);
    wait_irq("sat_irq", 200, n);
    check("sat_irq4", {31'd0, irq4}, 32'd1);
    bus_read(3'd3, d, d4);
    check("sat_res0_w32", d, 32'd50);
    check("sat_res0_w4", d4, 32'd15);
    bus_read(ADDR_STATUS, d, d4);
    check("sat_status_w32", d, 32'd2);
    check("sat_status_w4", d4, 32'd6);
    bus_write(ADDR_STATUS, 32'd6);
    bus_read(ADDR_STATUS, d, d4);
    check("ovf_w1c_w4", d4, 32'd0);

    // 5: GATE=0 stores 1; one-cycle pulse on ch3 lands in the single window cycle
    period = '{0, 0, 0, 0};
    repeat (4) tick();
    bus_write(ADDR_GATE, 32'd0);
    read_check("gate_zero", ADDR_GATE, 32'd1);
`ifdef FMEASURE_SYNC_EN
    man_bits = 4'b1000;
    tick();
    man_bits = 4'b0000;
    bus_write(ADDR_CTRL, 32'd6);
`else
    fork
      bus_write(ADDR_CTRL, 32'd6);
      begin
        tick();
        man_bits = 4'b1000;
        tick();
        man_bits = 4'b0000;
      end
    join
`endif
    wait_irq("gate1_irq", 20, n);
    read_check("gate1_res3", 3'd6, 32'd1);
    read_check("gate1_res0", 3'd3, 32'd0);

    // 6a: abort mid-window
    bus_write(ADDR_STATUS, 32'd6);
    period = '{0, 4, 0, 0};
    bus_write(ADDR_GATE, 32'd100);
    bus_write(ADDR_CTRL, 32'd6);
    repeat (30) tick();
    read_check("abort_busy_before", ADDR_STATUS, 32'd1);
    bus_write(ADDR_CTRL, 32'h8000_0004);
    read_check("abort_busy_after", ADDR_STATUS, 32'd0);
    read_check("abort_res1", 3'd4, 32'd0);
    read_check("abort_res3", 3'd6, 32'd1);
    repeat (150) tick();
    check("abort_no_irq", {31'd0, irq}, 32'd0);
    read_check("abort_status_late", ADDR_STATUS, 32'd0);

    // 6b: reset mid-window
    bus_write(ADDR_CTRL, 32'd7);
    repeat (20) tick();
    read_check("rst_mid_busy", ADDR_STATUS, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_readdata", readdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    apply_rst_tbl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
